// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared ALU arbiter.
// Per-requester fields are packed side by side; requester i sits at [i*W +: W].
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int W       = 32
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ*5-1:0] req_shamt;
    logic [NUM_REQ*4-1:0] req_ctrl;

    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [W-1:0]         rsp_result;
    logic                 rsp_zero;

    // requester side
    modport master (
        output req_valid, req_a, req_b, req_shamt, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    // arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_shamt, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// One transaction in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until owner accepts).
// A stalled owner blocks every other requester; that is intended behaviour.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [4:0]    alu_shamt,
    output logic [3:0]    alu_ctrl,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_zero,
    output logic          busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_ptr_next;
    logic            any_valid;
    logic            handshake;

    logic [W-1:0]    req_a_arr     [NUM_REQ];
    logic [W-1:0]    req_b_arr     [NUM_REQ];
    logic [4:0]      req_shamt_arr [NUM_REQ];
    logic [3:0]      req_ctrl_arr  [NUM_REQ];

    // Unpack the flat request buses into per-requester arrays so the grant can index them directly.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_a_arr[i]     = bus.req_a[i*W +: W];
        assign req_b_arr[i]     = bus.req_b[i*W +: W];
        assign req_shamt_arr[i] = bus.req_shamt[i*5 +: 5];
        assign req_ctrl_arr[i]  = bus.req_ctrl[i*4 +: 4];
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping explicitly at NUM_REQ.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_n;
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_n     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_n = IW'(idx);
            if (!any_valid && bus.req_valid[idx_n]) begin
                any_valid = 1'b1;
                grant     = idx_n;
            end
        end
    end

    // Pointer moves to the requester after the winner; non-power-of-two counts wrap to 0 by hand.
    always_comb begin
        if (grant == IW'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant + 1'b1;
        end
    end

    assign handshake = (state == IDLE) && any_valid;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a single EXEC cycle, RESP waits only on the owner's ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[owner]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs: ready only to the winner in IDLE, response valid only to the owner in RESP.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && !rst) begin
                    bus.req_ready[grant] = 1'b1;
                end
            end
            EXEC: begin
                busy = 1'b1;
            end
            RESP: begin
                busy                 = 1'b1;
                bus.rsp_valid[owner] = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Capture the granted operands and owner on handshake; ALU inputs stay frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_ctrl  <= 4'b0000;
            owner     <= '0;
            rr_ptr    <= '0;
        end else if (handshake) begin
            alu_a     <= req_a_arr[grant];
            alu_b     <= req_b_arr[grant];
            alu_shamt <= req_shamt_arr[grant];
            alu_ctrl  <= req_ctrl_arr[grant];
            owner     <= grant;
            rr_ptr    <= rr_ptr_next;
        end
    end

    // Register the ALU outputs at the end of EXEC so the response bus is stable through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
        end else if (state == EXEC) begin
            bus.rsp_result <= alu_result;
            bus.rsp_zero   <= alu_zero;
        end
    end

endmodule
